// File: rtl/exe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : exe_muldiv_unit
// Brief   : Iterative RV32M multiply/divide unit for the EXE stage
//           (shift-add multiply, restoring divide, one bit per cycle).
// Rev     : 1.0  initial release
// ============================================================================
module exe_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs1_rdata,
    input  logic [XLEN-1:0] rs2_rdata,
    input  logic            flush,
    input  logic            pipe_stall,
    output logic            stall_req,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int c_CW = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_LAST     = c_CW'(XLEN - 1);
    localparam logic [2:0]      c_F3_MUL    = 3'b000;
    localparam logic [2:0]      c_F3_MULH   = 3'b001;
    localparam logic [2:0]      c_F3_MULHSU = 3'b010;
    localparam logic [2:0]      c_F3_MULHU  = 3'b011;
    localparam logic [2:0]      c_F3_DIV    = 3'b100;
    localparam logic [2:0]      c_F3_DIVU   = 3'b101;
    localparam logic [2:0]      c_F3_REM    = 3'b110;
    localparam logic [2:0]      c_F3_REMU   = 3'b111;
    localparam logic [XLEN-1:0] c_MIN       = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_ONES      = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_f3;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [c_CW-1:0]     r_count;
    logic [XLEN-1:0]     r_result;

    logic                w_unused;
    logic                w_is_m;
    logic [2:0]          w_f3;
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_b_zero;
    logic                w_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_res;
    logic                w_start;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;

    assign w_unused   = &{1'b0, inst[24:15], inst[11:7]};

    // ---------------- decode and operand conditioning ----------------
    assign w_is_m     = (inst[6:0] == 7'b0110011) && (inst[31:25] == 7'b0000001);
    assign w_f3       = inst[14:12];
    assign w_is_div   = w_f3[2];
    assign w_a_signed = (w_f3 == c_F3_MUL) || (w_f3 == c_F3_MULH) || (w_f3 == c_F3_MULHSU)
                     || (w_f3 == c_F3_DIV) || (w_f3 == c_F3_REM);
    assign w_b_signed = (w_f3 == c_F3_MUL) || (w_f3 == c_F3_MULH)
                     || (w_f3 == c_F3_DIV) || (w_f3 == c_F3_REM);
    assign w_sa       = w_a_signed && rs1_rdata[XLEN-1];
    assign w_sb       = w_b_signed && rs2_rdata[XLEN-1];
    assign w_mag_a    = w_sa ? (~rs1_rdata + 1'b1) : rs1_rdata;
    assign w_mag_b    = w_sb ? (~rs2_rdata + 1'b1) : rs2_rdata;
    assign w_b_zero   = (rs2_rdata == '0);
    assign w_ovf      = ((w_f3 == c_F3_DIV) || (w_f3 == c_F3_REM))
                     && (rs1_rdata == c_MIN) && (rs2_rdata == c_ONES);
    assign w_fast     = (EARLY_OUT != 0) && w_is_div && (w_b_zero || w_ovf);
    assign w_fast_res = w_b_zero ? (w_f3[1] ? rs1_rdata : c_ONES)
                                 : (w_f3[1] ? '0 : c_MIN);
    assign w_start    = (r_state == S_IDLE) && w_is_m && !flush;

    // ---------------- one iteration step ----------------
    // Multiply: multiplier sits in the low half and shifts out as the product fills in.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

    assign w_acc_next = r_f3[2] ? w_div_next : w_mul_next;
    assign w_prod_s   = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_quo      = w_acc_next[XLEN-1:0];
    assign w_rem      = w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        w_final = w_prod_s[XLEN-1:0];
        case (r_f3)
            c_F3_MULH, c_F3_MULHSU, c_F3_MULHU: w_final = w_prod_s[2*XLEN-1:XLEN];
            c_F3_DIV, c_F3_DIVU:                w_final = r_neg_q ? (~w_quo + 1'b1) : w_quo;
            c_F3_REM, c_F3_REMU:                w_final = r_neg_r ? (~w_rem + 1'b1) : w_rem;
            default:                            ;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_next = w_fast ? S_DONE : S_CALC;
            S_CALC: if (r_count == c_LAST) w_state_next = S_DONE;
            S_DONE: if (!pipe_stall) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush) w_state_next = S_IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f3     <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_start) begin
            r_f3     <= w_f3;
            r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
            r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            // A zero divisor yields all-ones quotient regardless of signs.
            r_neg_q  <= (w_sa ^ w_sb) && !(w_is_div && w_b_zero);
            r_neg_r  <= w_sa;
            r_count  <= '0;
            if (w_fast) r_result <= w_fast_res;
        end else if ((r_state == S_CALC) && !flush) begin
            r_acc    <= w_acc_next;
            r_count  <= r_count + 1'b1;
            if (r_count == c_LAST) r_result <= w_final;
        end
    end

    assign stall_req    = !rst && w_is_m && !flush
                       && ((r_state == S_IDLE) || (r_state == S_CALC));
    assign result_valid = (r_state == S_DONE);
    assign result       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_exe_muldiv_unit
// Brief   : Self-checking bench; fast-path and full-iteration units side by side.
// Rev     : 1.0  initial release
// ============================================================================
module tb_exe_muldiv_unit;

    localparam logic [31:0] c_ADD  = 32'h00B5_0533;
    localparam logic [31:0] c_ADDI = 32'h02B5_0513;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst         [2];
    logic [31:0] rs1          [2];
    logic [31:0] rs2          [2];
    logic        flush        [2];
    logic        pipe_stall   [2];
    logic        stall_req    [2];
    logic        result_valid [2];
    logic [31:0] result       [2];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    exe_muldiv_unit #(.XLEN(32), .EARLY_OUT(1)) u_dut_fast (
        .clk(clk), .rst(rst), .inst(inst[0]), .rs1_rdata(rs1[0]), .rs2_rdata(rs2[0]),
        .flush(flush[0]), .pipe_stall(pipe_stall[0]), .stall_req(stall_req[0]),
        .result_valid(result_valid[0]), .result(result[0])
    );

    exe_muldiv_unit #(.XLEN(32), .EARLY_OUT(0)) u_dut_slow (
        .clk(clk), .rst(rst), .inst(inst[1]), .rs1_rdata(rs1[1]), .rs2_rdata(rs2[1]),
        .flush(flush[1]), .pipe_stall(pipe_stall[1]), .stall_req(stall_req[1]),
        .result_valid(result_valid[1]), .result(result[1])
    );

    // Architectural RV32M results computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] pv;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        pv  = 64'd0;
        case (f3)
            3'd0: begin pv = sa * sb; return pv[31:0];  end
            3'd1: begin pv = sa * sb; return pv[63:32]; end
            3'd2: begin pv = sa * ub; return pv[63:32]; end
            3'd3: begin pv = ua * ub; return pv[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                pv = sa / sb; return pv[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                pv = sa % sb; return pv[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_stalls(input int s, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b);
        logic fast;
        fast = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return (s == 0 && fast) ? 1 : 33;
    endfunction

    function automatic logic [31:0] mk_m(input logic [2:0] f3);
        return {7'b0000001, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
    endfunction

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge with the unit idle; returns the same way.
    task automatic run_op(input int s, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int          n;
        int          exp_n;
        logic [31:0] exp;
        exp   = ref_m(f3, a, b);
        exp_n = exp_stalls(s, f3, a, b);
        n     = 0;
        inst[s] = mk_m(f3);
        rs1[s]  = a;
        rs2[s]  = b;
        @(negedge clk);
        while (stall_req[s] === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        n_total++;
        if (n !== exp_n) $display("FAIL %s stalls: got %0d want %0d", tag, n, exp_n);
        else n_pass++;
        n_total++;
        if (result_valid[s] !== 1'b1) $display("FAIL %s valid: got %b want 1", tag, result_valid[s]);
        else n_pass++;
        n_total++;
        if (result[s] !== exp) $display("FAIL %s result: got %h want %h (f3=%0d a=%h b=%h)",
                                         tag, result[s], exp, f3, a, b);
        else n_pass++;
        sync();
        inst[s] = c_ADD;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            inst[s] = mk_m(3'd0); rs1[s] = 32'd5; rs2[s] = 32'd6;
            flush[s] = 1'b0; pipe_stall[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_total++;
            if (stall_req[s] !== 1'b0) $display("FAIL reset stall_req[%0d]: got %b want 0", s, stall_req[s]);
            else n_pass++;
            n_total++;
            if (result_valid[s] !== 1'b0) $display("FAIL reset valid[%0d]: got %b want 0", s, result_valid[s]);
            else n_pass++;
            n_total++;
            if (result[s] !== 32'd0) $display("FAIL reset result[%0d]: got %h want 0", s, result[s]);
            else n_pass++;
            inst[s] = c_ADD;
        end
        rst = 1'b0;
        sync();
    endtask

    task automatic test_non_m();
        for (int k = 0; k < 4; k++) begin
            inst[0] = (k % 2 == 0) ? c_ADD : c_ADDI;
            @(negedge clk);
            n_total++;
            if (stall_req[0] !== 1'b0 || result_valid[0] !== 1'b0)
                $display("FAIL non_m: got stall=%b valid=%b want 0/0", stall_req[0], result_valid[0]);
            else n_pass++;
        end
        inst[0] = c_ADD;
        sync();
    endtask

    task automatic test_directed();
        for (int s = 0; s < 2; s++) begin
            run_op(s, 3'd0, 32'd7,         32'hFFFF_FFFD, "mul_7_m3");
            run_op(s, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
            run_op(s, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ones");
            run_op(s, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
            run_op(s, 3'd4, 32'hFFFF_FFF9, 32'd2,         "div_m7_2");
            run_op(s, 3'd6, 32'hFFFF_FFF9, 32'd2,         "rem_m7_2");
            run_op(s, 3'd7, 32'd100,       32'd7,         "remu_100_7");
            run_op(s, 3'd5, 32'd1234,      32'd0,         "divu_by0");
            run_op(s, 3'd4, 32'hFFFF_FFF0, 32'd0,         "div_neg_by0");
            run_op(s, 3'd6, 32'hFFFF_FFF0, 32'd0,         "rem_neg_by0");
            run_op(s, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
            run_op(s, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        end
    endtask

    task automatic test_flush();
        inst[0] = mk_m(3'd4); rs1[0] = 32'hFFFF_FFF9; rs2[0] = 32'd2;
        @(negedge clk);
        repeat (10) @(negedge clk);
        flush[0] = 1'b1;
        #1;
        n_total++;
        if (stall_req[0] !== 1'b0) $display("FAIL flush stall_req: got %b want 0", stall_req[0]);
        else n_pass++;
        sync();
        flush[0] = 1'b0;
        inst[0]  = c_ADD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if (result_valid[0] !== 1'b0 || stall_req[0] !== 1'b0)
                $display("FAIL flush after: got valid=%b stall=%b want 0/0", result_valid[0], stall_req[0]);
            else n_pass++;
        end
        sync();
        run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, "div_after_flush");
    endtask

    task automatic test_pipe_stall();
        int n = 0;
        inst[0] = mk_m(3'd0); rs1[0] = 32'd7; rs2[0] = 32'hFFFF_FFFD;
        pipe_stall[0] = 1'b1;
        @(negedge clk);
        while (stall_req[0] === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        n_total++;
        if (n !== 33) $display("FAIL hold stalls: got %0d want 33", n);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (result_valid[0] !== 1'b1 || stall_req[0] !== 1'b0 || result[0] !== 32'hFFFF_FFEB)
                $display("FAIL hold cycle %0d: got valid=%b stall=%b res=%h want 1/0/ffffffeb",
                         k, result_valid[0], stall_req[0], result[0]);
            else n_pass++;
            if (k == 2) pipe_stall[0] = 1'b0;
            @(negedge clk);
        end
        // The third DONE cycle released pipe_stall, so this cycle is IDLE again.
        n_total++;
        if (result_valid[0] !== 1'b0) $display("FAIL hold release valid: got %b want 0", result_valid[0]);
        else n_pass++;
        inst[0] = c_ADD;
        sync();
        run_op(0, 3'd0, 32'd12345, 32'd678, "mul_after_hold");
    endtask

    task automatic test_reset_mid();
        inst[0] = mk_m(3'd0); rs1[0] = 32'd99; rs2[0] = 32'd77;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (stall_req[0] !== 1'b0 || result_valid[0] !== 1'b0 || result[0] !== 32'd0)
            $display("FAIL reset_mid: got stall=%b valid=%b res=%h want 0/0/0",
                     stall_req[0], result_valid[0], result[0]);
        else n_pass++;
        inst[0] = c_ADD;
        @(negedge clk);
        rst = 1'b0;
        sync();
        run_op(0, 3'd0, 32'd99, 32'd77, "mul_after_reset");
    endtask

    task automatic test_random(input int s, input int count);
        for (int k = 0; k < count; k++) begin
            run_op(s, 3'($urandom_range(0, 7)), pick_opnd(), pick_opnd(), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_non_m();
        test_directed();
        test_flush();
        test_pipe_stall();
        test_reset_mid();
        test_random(0, 40);
        test_random(1, 15);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EXE stage, fed directly by the EXE stage register outputs (inst, rs1_rdata, rs2_rdata).
- Holds the pipeline through a stall request while it computes.
- Presents a registered 32-bit result to the EXE result mux, to be captured by the MEM stage register.
- Non-M instructions pass untouched: unit stays idle, stall_req stays 0.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- EARLY_OUT, 1, 1 enables single-cycle fast paths for divide-by-zero and signed overflow; 0 sends them through the full iteration with identical results.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inst  input  32  instruction from EXE stage register.
- rs1_rdata  input  32  operand A from EXE stage register.
- rs2_rdata  input  32  operand B from EXE stage register.
- flush  input  1  EXE flush (branch mispredict/trap); aborts any operation.
- pipe_stall  input  1  stall from elsewhere (e.g. MEM wait); EXE register will not advance this cycle.
- stall_req  output  1  combinational request to stall IF/ID/EXE registers.
- result_valid  output  1  result holds the current M instruction's value.
- result  output  32  M-extension result.

Behaviour:
- Decode: is_m = (inst[6:0]==7'b0110011) && (inst[31:25]==7'b0000001).
  - funct3 = inst[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Reset (async, any state): state=IDLE, count=0, result=0, result_valid=0, internal operand/accumulator registers=0. stall_req=0 while rst is high.
- States: IDLE, CALC, DONE.
- IDLE:
  - If is_m && !flush: latch operands and op.
    - Signed ops store magnitudes plus result sign; MULHSU treats rs2 as unsigned.
    - Go to CALC with count=0.
  - If EARLY_OUT and the op is a fast-path case, go directly to DONE with the result loaded.
- CALC:
  - One iteration per cycle, count increments.
  - MUL*: shift-add, 64-bit product.
  - DIV*/REM*: restoring divide, one quotient bit per cycle.
  - At count==31 the final result is registered, with sign correction and selection of low/high product or quotient/remainder. Next state is DONE.
- DONE: result_valid=1. If pipe_stall=1, stay in DONE (result held, no restart); else go to IDLE.
- stall_req = is_m && !flush && (state==IDLE || state==CALC).
  - It deasserts in the DONE cycle so the EXE register advances together with result capture.
- Latency: normal op = 33 stall cycles (1 IDLE + 32 CALC), then 1 DONE cycle. Fast path = 1 stall cycle, then DONE.
- Fast paths (EARLY_OUT=1):
  - Divisor==0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = rs1.
  - DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - With EARLY_OUT=0 the iteration must produce the same values.
- Sign rules: remainder sign = dividend sign; quotient negated when operand signs differ. All arithmetic is modulo 2^32 on the result.
- flush: in any state, the next state is IDLE and result_valid=0 next cycle. stall_req is forced 0 in the flush cycle. flush has priority over pipe_stall and over starting a new op.
- Back-to-back M instructions:
  - The DONE→IDLE edge coincides with the EXE register loading the next instruction.
  - The next op starts in the following IDLE cycle.
  - No result of the previous op leaks, since result_valid is 0 in IDLE.
- Reset mid-CALC: immediate return to IDLE, outputs at reset values.
- Non-M instruction in IDLE: no state change, stall_req=0, result_valid=0.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (−3) → stall_req high 33 cycles; DONE cycle result=0xFFFFFFEB, result_valid=1, stall_req=0.
- MULHU rs1=rs2=0xFFFFFFFF → result=0xFFFFFFFE. MULH with the same operands → result=0x00000000.
- DIV rs1=0xFFFFFFF9 (−7), rs2=2 → result=0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. REMU 100/7 → 2.
- DIVU rs2=0 → 1 stall cycle, result=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → result=0x80000000. REM of the same → 0. Repeat with EARLY_OUT=0: same values after 33 cycles.
- DIV started, flush asserted on CALC cycle 10 → stall_req=0 that cycle, IDLE next cycle, result_valid=0. A following ADD causes no stall.
- MUL completes while pipe_stall=1 for 3 cycles → DONE held 3 cycles with result stable and no restart. Returns to IDLE after pipe_stall drops. A back-to-back second MUL then starts correctly.
